// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared types and constants for the two-source bus arbiter.
//   state_t : arbiter sequencing states
//   src_t   : source identifier (SRC1 / SRC2)
//   CTL_*   : 2-bit mux select codes driven onto Control
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    TURN = 2'b01,
    OWN1 = 2'b10,
    OWN2 = 2'b11
  } state_t;

  typedef enum logic {
    SRC1 = 1'b0,
    SRC2 = 1'b1
  } src_t;

  localparam logic [1:0] CTL_IN1  = 2'b00;  // bus <- source 1
  localparam logic [1:0] CTL_IN2  = 2'b01;  // bus <- source 2
  localparam logic [1:0] CTL_TURN = 2'b10;  // bus <- 4'b0011 turnaround
  localparam logic [1:0] CTL_IDLE = 2'b11;  // bus <- 4'b0000

endpackage

// File: rtl/bus_hold_timer.sv
// bus_hold_timer: saturating count of owned cycles.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_clr          : hold count at zero (asserted while nobody owns the bus)
//   i_en           : an owned cycle is in progress
//   o_expired      : the current owned cycle is the MAX_HOLD-th one
// The counter saturates at MAX_HOLD; width is clog2(MAX_HOLD+1).
module bus_hold_timer #(
  parameter int MAX_HOLD = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int CW = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_HOLD);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_HOLD - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                      r_cnt <= '0;
    else if (i_clr)                    r_cnt <= '0;
    else if (i_en && r_cnt != CNT_MAX) r_cnt <= r_cnt + CW'(1);
  end

  // The count reaches MAX_HOLD on the edge that closes this cycle, so the
  // owner is released after exactly MAX_HOLD owned cycles.
  assign o_expired = i_en && (r_cnt >= CNT_LAST);

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-requester arbiter/sequencer for the shared 4-bit bus mux.
//   Clock, Reset_n    : clock (rising edge), async active-low reset
//   Req1, Req2        : bus requests, held high until done
//   Done1, Done2      : one-cycle release strobes (ignored unless owner)
//   Grant1, Grant2    : registered ownership grants
//   Control           : mux select (00 src1, 01 src2, 10 turnaround, 11 idle)
//   Busy              : high in any state other than IDLE
//   Timeout           : one-cycle pulse on the TURN following a forced release
// Optional feature macro: BUS_ARB_TIMEOUT_EN enables the hold timer and
// forced release after MAX_HOLD owned cycles while the other side waits.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic       Req1,
  input  logic       Req2,
  input  logic       Done1,
  input  logic       Done2,
  output logic       Grant1,
  output logic       Grant2,
  output logic [1:0] Control,
  output logic       Busy,
  output logic       Timeout
);

  state_t     r_state;
  src_t       r_next;
  src_t       r_last;
  logic       r_grant1, r_grant2, r_busy, r_timeout;
  logic [1:0] r_ctl;

  logic w_owning, w_expired, w_force;
  logic w_req_tgt, w_req_oth;

  assign w_owning  = (r_state == OWN1) || (r_state == OWN2);
  assign w_req_tgt = (r_next == SRC1) ? Req1 : Req2;
  assign w_req_oth = (r_next == SRC1) ? Req2 : Req1;

`ifdef BUS_ARB_TIMEOUT_EN
  bus_hold_timer #(.MAX_HOLD(MAX_HOLD)) u_hold (
    .i_clk    (Clock),
    .i_rst_n  (Reset_n),
    .i_clr    (!w_owning),
    .i_en     (w_owning),
    .o_expired(w_expired)
  );
`else
  assign w_expired = 1'b0;
`endif

  // Forced release only makes sense when the other side is waiting.
  assign w_force = w_expired && ((r_state == OWN1) ? Req2 : Req1);

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state   <= IDLE;
      r_next    <= SRC1;
      r_last    <= SRC2;
      r_grant1  <= 1'b0;
      r_grant2  <= 1'b0;
      r_ctl     <= CTL_IDLE;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (Req1 || Req2) begin
            r_state <= TURN;
            r_ctl   <= CTL_TURN;
            r_busy  <= 1'b1;
            // Round-robin on contention: favour whoever did not own last.
            if (Req1 && Req2) r_next <= (r_last == SRC1) ? SRC2 : SRC1;
            else              r_next <= Req1 ? SRC1 : SRC2;
          end
        end
        TURN: begin
          if (w_req_tgt) begin
            r_state  <= (r_next == SRC1) ? OWN1 : OWN2;
            r_ctl    <= (r_next == SRC1) ? CTL_IN1 : CTL_IN2;
            r_grant1 <= (r_next == SRC1);
            r_grant2 <= (r_next == SRC2);
          end else if (w_req_oth) begin
            // Target withdrew; retarget without leaving the turnaround.
            r_next <= (r_next == SRC1) ? SRC2 : SRC1;
          end else begin
            r_state <= IDLE;
            r_ctl   <= CTL_IDLE;
            r_busy  <= 1'b0;
          end
        end
        OWN1: begin
          if (Done1 || !Req1 || w_force) begin
            r_last   <= SRC1;
            r_grant1 <= 1'b0;
            if (Req2) begin
              r_state   <= TURN;
              r_next    <= SRC2;
              r_ctl     <= CTL_TURN;
              r_timeout <= w_force && Req1 && !Done1;
            end else begin
              r_state <= IDLE;
              r_ctl   <= CTL_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        OWN2: begin
          if (Done2 || !Req2 || w_force) begin
            r_last   <= SRC2;
            r_grant2 <= 1'b0;
            if (Req1) begin
              r_state   <= TURN;
              r_next    <= SRC1;
              r_ctl     <= CTL_TURN;
              r_timeout <= w_force && Req2 && !Done2;
            end else begin
              r_state <= IDLE;
              r_ctl   <= CTL_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state  <= IDLE;
          r_ctl    <= CTL_IDLE;
          r_grant1 <= 1'b0;
          r_grant2 <= 1'b0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign Grant1  = r_grant1;
  assign Grant2  = r_grant2;
  assign Control = r_ctl;
  assign Busy    = r_busy;
  assign Timeout = r_timeout;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed + randomized bench for bus_arbiter (MAX_HOLD=4),
// checked cycle by cycle against a rule-level reference model.
module tb_bus_arbiter;

  localparam int MAX_HOLD = 4;
`ifdef BUS_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       Clock = 1'b0;
  logic       Reset_n = 1'b0;
  logic       Req1 = 1'b0, Req2 = 1'b0, Done1 = 1'b0, Done2 = 1'b0;
  logic       Grant1, Grant2, Busy, Timeout;
  logic [1:0] Control;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: mode 0 idle, 1 turnaround, 2 owned; sources are 1/2.
  int         m_mode, m_tgt, m_last, m_held;
  bit         m_to;
  logic [1:0] prev_ctl;
  bit         saw_timeout;

  bus_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .Clock  (Clock),
    .Reset_n(Reset_n),
    .Req1   (Req1),
    .Req2   (Req2),
    .Done1  (Done1),
    .Done2  (Done2),
    .Grant1 (Grant1),
    .Grant2 (Grant2),
    .Control(Control),
    .Busy   (Busy),
    .Timeout(Timeout)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_tgt = 1; m_last = 2; m_held = 0; m_to = 1'b0;
    prev_ctl = 2'b11;
  endtask

  task automatic model_edge(input bit r1, input bit r2, input bit d1, input bit d2);
    int  oth;
    bit  rq_own, rq_oth, dn, forced;
    m_to = 1'b0;
    case (m_mode)
      0: if (r1 || r2) begin
        m_mode = 1;
        if (r1 && r2) m_tgt = (m_last == 1) ? 2 : 1;
        else          m_tgt = r1 ? 1 : 2;
      end
      1: begin
        oth = 3 - m_tgt;
        if ((m_tgt == 1) ? r1 : r2) begin m_mode = 2; m_held = 0; end
        else if ((oth == 1) ? r1 : r2) m_tgt = oth;
        else m_mode = 0;
      end
      default: begin
        oth    = 3 - m_tgt;
        rq_own = (m_tgt == 1) ? r1 : r2;
        rq_oth = (oth == 1) ? r1 : r2;
        dn     = (m_tgt == 1) ? d1 : d2;
        m_held = m_held + 1;
        forced = TO_EN && (m_held >= MAX_HOLD) && rq_oth;
        if (dn || !rq_own || forced) begin
          m_last = m_tgt;
          m_to   = forced && rq_own && !dn;
          if (rq_oth) begin m_mode = 1; m_tgt = oth; end
          else m_mode = 0;
        end
      end
    endcase
  endtask

  task automatic check_all(input string where);
    logic [1:0] ectl;
    bit         sw;
    ectl = (m_mode == 0) ? 2'b11 : (m_mode == 1) ? 2'b10 : (m_tgt == 1) ? 2'b00 : 2'b01;
    chk({where, ".ctl"},  Control, ectl);
    chk({where, ".g1"},   {1'b0, Grant1},  {1'b0, (m_mode == 2) && (m_tgt == 1)});
    chk({where, ".g2"},   {1'b0, Grant2},  {1'b0, (m_mode == 2) && (m_tgt == 2)});
    chk({where, ".busy"}, {1'b0, Busy},    {1'b0, m_mode != 0});
    chk({where, ".to"},   {1'b0, Timeout}, {1'b0, m_to});
    sw = ((prev_ctl == 2'b00) && (Control == 2'b01)) ||
         ((prev_ctl == 2'b01) && (Control == 2'b00));
    chk({where, ".noswitch"}, {1'b0, sw}, 2'b00);
    prev_ctl = Control;
    if (Timeout === 1'b1) saw_timeout = 1'b1;
  endtask

  task automatic cyc(input string where);
    @(posedge Clock);
    model_edge(Req1, Req2, Done1, Done2);
    @(negedge Clock);
    check_all(where);
  endtask

  // Called just after a falling edge; reset effect is checked before any
  // rising edge can occur.
  task automatic do_reset(input string where);
    Reset_n = 1'b0;
    #2;
    model_reset();
    check_all(where);
    #1;
    Reset_n = 1'b1;
  endtask

  initial begin
    model_reset();
    saw_timeout = 1'b0;
    repeat (3) @(negedge Clock);
    check_all("reset_hold");
    Reset_n = 1'b1;
    cyc("reset_rel");

    // Single request, ignored Done2, Done1 release
    Req1 = 1'b1; cyc("req1_turn");
    cyc("req1_grant");
    cyc("own1_a");
    Done2 = 1'b1; cyc("done2_ignored");
    Done2 = 1'b0; cyc("own1_b");
    Done1 = 1'b1; cyc("done1_release");
    Done1 = 1'b0; Req1 = 1'b0; cyc("idle_after");

    // Simultaneous requests right out of reset: source 1 first
    do_reset("rst_before_both");
    Req1 = 1'b1; Req2 = 1'b1; cyc("both_turn");
    cyc("both_own1");
    chk("both_first_is_1", {1'b0, Grant1}, 2'b01);
    Done1 = 1'b1; cyc("both_done1");
    Done1 = 1'b0; Req1 = 1'b0; cyc("both_own2");
    chk("both_second_is_2", {1'b0, Grant2}, 2'b01);
    Done2 = 1'b1; cyc("own2_done");
    Done2 = 1'b0; Req2 = 1'b0; cyc("both_idle");

    // Request withdrawn during TURN
    Req2 = 1'b1; cyc("wd_turn");
    Req2 = 1'b0; cyc("wd_idle");
    cyc("wd_stay");

    // Hold limit with the other side waiting
    Req1 = 1'b1; cyc("hold_turn");
    cyc("hold_own1");
    Req2 = 1'b1;
    repeat (12) cyc("hold");
    chk("timeout_seen", {1'b0, saw_timeout}, {1'b0, TO_EN});
    Req1 = 1'b0; Req2 = 1'b0;
    repeat (3) cyc("hold_drain");

    // Reset mid-ownership drops the grant asynchronously
    Req1 = 1'b1; cyc("mid_turn");
    cyc("mid_own1");
    do_reset("mid_reset");
    chk("mid_reset_grant", {1'b0, Grant1}, 2'b00);
    Req1 = 1'b0;
    cyc("mid_after");

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(4, 0) == 0) Req1 = ~Req1;
      if ($urandom_range(4, 0) == 0) Req2 = ~Req2;
      Done1 = ($urandom_range(5, 0) == 0);
      Done2 = ($urandom_range(5, 0) == 0);
      cyc("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
